// File: rtl/fifo_pkg.sv
// Shared types and helpers for the parameterised synchronous FIFO family.
package fifo_pkg;

    // Read-side behaviour of the FIFO output port.
    typedef enum logic {
        FIFO_REGISTERED = 1'b0,
        FIFO_FWFT       = 1'b1
    } fifo_mode_e;

    // Width of pointers and of the occupancy counter: one extra bit beyond
    // the memory index so that full and empty remain distinguishable.
    function automatic int fifo_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_sdp_ram.sv
// Simple dual-port storage array: one write port, one synchronous read port.
// A read of the address being written in the same cycle returns the new word.
module fifo_sdp_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_W     = 6
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [ADDR_W-1:0]     waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_W-1:0]     raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Write port plus write-first registered read port; holds when not enabled.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= (we_i && (waddr_i == raddr_i)) ? wdata_i : mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with registered-read or first-word-fall-through output,
// occupancy count, programmable almost flags and overflow/underflow pulses.
module param_sync_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 64,
    parameter int FWFT       = 0,
    parameter int AF_THRESH  = DEPTH - 4,
    parameter int AE_THRESH  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_valid,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    output logic                          wr_ready,
    input  logic                          rd_ready,
    output logic [DATA_WIDTH-1:0]         rd_data,
    output logic                          rd_valid,
    output logic [fifo_cnt_w(DEPTH)-1:0]  count,
    output logic                          full,
    output logic                          empty,
    output logic                          almost_full,
    output logic                          almost_empty,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int         CNT_W  = fifo_cnt_w(DEPTH);
    localparam int         ADDR_W = CNT_W - 1;
    localparam fifo_mode_e MODE   = (FWFT != 0) ? FIFO_FWFT : FIFO_REGISTERED;

    localparam logic [CNT_W-1:0] AF_LVL = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] AE_LVL = CNT_W'(AE_THRESH);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_chk_depth
        $error("param_sync_fifo: DEPTH must be a power of two >= 2");
    end
    if (DATA_WIDTH < 1) begin : g_chk_width
        $error("param_sync_fifo: DATA_WIDTH must be >= 1");
    end
    if ((AF_THRESH < 1) || (AF_THRESH > DEPTH)) begin : g_chk_af
        $error("param_sync_fifo: AF_THRESH must be in 1..DEPTH");
    end
    if ((AE_THRESH < 0) || (AE_THRESH > DEPTH - 1)) begin : g_chk_ae
        $error("param_sync_fifo: AE_THRESH must be in 0..DEPTH-1");
    end

    logic [CNT_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  overflow_q;
    logic                  underflow_q;
    logic                  push;
    logic                  pop;
    logic                  ram_re;
    logic [ADDR_W-1:0]     ram_raddr;
    logic [DATA_WIDTH-1:0] ram_rdata;

    // rd_ptr_q is the consumer-side pointer: it moves only when the
    // consumer takes a word, so wr_ptr_q - rd_ptr_q always equals count.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                   (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);

    assign wr_ready     = !full;
    assign count        = count_q;
    assign almost_full  = (count_q >= AF_LVL);
    assign almost_empty = (count_q <= AE_LVL);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    assign push = !rst && wr_valid && wr_ready;
    assign pop  = !rst && rd_ready && ((MODE == FIFO_FWFT) ? rd_valid : !empty);

    // Next-state for pointers and occupancy counter.
    always_comb begin
        wr_ptr_d = wr_ptr_q + CNT_W'(push);
        rd_ptr_d = rd_ptr_q + CNT_W'(pop);
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Pointer, counter and error-pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= wr_valid && !wr_ready;
            underflow_q <= (MODE == FIFO_REGISTERED) && rd_ready && empty;
        end
    end

    fifo_sdp_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_W     (ADDR_W)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (push),
        .waddr_i (wr_ptr_q[ADDR_W-1:0]),
        .wdata_i (wr_data),
        .re_i    (ram_re),
        .raddr_i (ram_raddr),
        .rdata_o (ram_rdata)
    );

    if (MODE == FIFO_REGISTERED) begin : g_reg
        logic rvalid_q;
        logic loaded_q;

        // The RAM read register is the output register; loaded_q masks it
        // to zero until the first pop after reset.
        always_ff @(posedge clk) begin
            if (rst) begin
                rvalid_q <= 1'b0;
                loaded_q <= 1'b0;
            end else begin
                rvalid_q <= pop;
                if (pop) begin
                    loaded_q <= 1'b1;
                end
            end
        end

        assign ram_re    = pop;
        assign ram_raddr = rd_ptr_q[ADDR_W-1:0];
        assign rd_valid  = rvalid_q;
        assign rd_data   = loaded_q ? ram_rdata : '0;
    end else begin : g_fwft
        logic [CNT_W-1:0]      fetch_ptr_q, fetch_ptr_d;
        logic                  out_valid_q, out_valid_d;
        logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
        logic                  ram_has;

        // The RAM is read every cycle at the next fetch pointer, so ram_rdata
        // always shows the oldest unfetched word. When the RAM holds nothing
        // unfetched, an incoming push goes straight into the output register.
        assign ram_has = (wr_ptr_q != fetch_ptr_q);

        // Output-register refill: from RAM head first, else from the write port.
        always_comb begin
            fetch_ptr_d = fetch_ptr_q;
            out_valid_d = out_valid_q;
            out_data_d  = out_data_q;
            if (!out_valid_q || pop) begin
                if (ram_has) begin
                    out_data_d  = ram_rdata;
                    out_valid_d = 1'b1;
                    fetch_ptr_d = fetch_ptr_q + CNT_W'(1);
                end else if (push) begin
                    out_data_d  = wr_data;
                    out_valid_d = 1'b1;
                    fetch_ptr_d = fetch_ptr_q + CNT_W'(1);
                end else begin
                    out_valid_d = 1'b0;
                end
            end
        end

        // Show-ahead output register and fetch pointer.
        always_ff @(posedge clk) begin
            if (rst) begin
                fetch_ptr_q <= '0;
                out_valid_q <= 1'b0;
                out_data_q  <= '0;
            end else begin
                fetch_ptr_q <= fetch_ptr_d;
                out_valid_q <= out_valid_d;
                out_data_q  <= out_data_d;
            end
        end

        assign ram_re    = 1'b1;
        assign ram_raddr = fetch_ptr_d[ADDR_W-1:0];
        assign rd_valid  = out_valid_q;
        assign rd_data   = out_data_q;
    end

endmodule

// File: tb/tb_param_sync_fifo.sv
// Self-checking bench: one registered-read FIFO and one show-ahead FIFO,
// both DEPTH=8, checked against queue models and a vector table.
module tb_param_sync_fifo;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    // Registered-read instance (DEPTH 8, AF 6, AE 2)
    logic       r_wv, r_rr;
    logic [7:0] r_wd, r_rd_data;
    logic       r_wr_ready, r_rd_valid, r_full, r_empty, r_af, r_ae, r_ovf, r_unf;
    logic [3:0] r_count;

    // Show-ahead instance (DEPTH 8, default thresholds)
    logic        f_wv, f_rr;
    logic [15:0] f_wd, f_rd_data;
    logic        f_wr_ready, f_rd_valid, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
    logic [3:0]  f_count;

    param_sync_fifo #(
        .DATA_WIDTH (8),
        .DEPTH      (8),
        .FWFT       (0),
        .AF_THRESH  (6),
        .AE_THRESH  (2)
    ) u_reg (
        .clk          (clk),
        .rst          (rst),
        .wr_valid     (r_wv),
        .wr_data      (r_wd),
        .wr_ready     (r_wr_ready),
        .rd_ready     (r_rr),
        .rd_data      (r_rd_data),
        .rd_valid     (r_rd_valid),
        .count        (r_count),
        .full         (r_full),
        .empty        (r_empty),
        .almost_full  (r_af),
        .almost_empty (r_ae),
        .overflow     (r_ovf),
        .underflow    (r_unf)
    );

    param_sync_fifo #(
        .DATA_WIDTH (16),
        .DEPTH      (8),
        .FWFT       (1)
    ) u_fwft (
        .clk          (clk),
        .rst          (rst),
        .wr_valid     (f_wv),
        .wr_data      (f_wd),
        .wr_ready     (f_wr_ready),
        .rd_ready     (f_rr),
        .rd_data      (f_rd_data),
        .rd_valid     (f_rd_valid),
        .count        (f_count),
        .full         (f_full),
        .empty        (f_empty),
        .almost_full  (f_af),
        .almost_empty (f_ae),
        .overflow     (f_ovf),
        .underflow    (f_unf)
    );

    int errors = 0;
    int checks = 0;

    logic [7:0]  rq[$];
    logic [15:0] fq[$];
    int          f_recv;
    int          f_sent;

    typedef struct {
        logic       wv;
        logic [7:0] wd;
        logic       rr;
        logic [3:0] cnt;
        logic       full;
        logic       empty;
        logic       af;
        logic       ae;
        logic       ovf;
        logic       unf;
    } vec_t;

    vec_t tbl[19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One registered-read cycle: model decides acceptance from its own state.
    task automatic reg_cycle(input logic wv, input logic [7:0] wd, input logic rr);
        logic       do_push;
        logic       do_pop;
        logic [7:0] exp_d;
        do_push = wv && (rq.size() < 8);
        do_pop  = rr && (rq.size() > 0);
        exp_d   = '0;
        if (do_pop) exp_d = rq.pop_front();
        if (do_push) rq.push_back(wd);
        r_wv = wv;
        r_wd = wd;
        r_rr = rr;
        @(posedge clk);
        #1;
        chk("reg_count", 32'(r_count), 32'(rq.size()));
        chk("reg_rd_valid", 32'(r_rd_valid), 32'(do_pop));
        if (do_pop) chk("reg_rd_data", 32'(r_rd_data), 32'(exp_d));
    endtask

    // One show-ahead cycle: compare the head before the edge, then the count after.
    task automatic fwft_step(input logic wv, input logic [15:0] wd, input logic rr);
        logic [15:0] exp_d;
        f_wv = wv;
        f_wd = wd;
        f_rr = rr;
        chk("fwft_rd_valid", 32'(f_rd_valid), 32'(fq.size() != 0));
        if (f_rd_valid && rr) begin
            if (fq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL fwft_extra_word: got %0h expected none", f_rd_data);
            end else begin
                exp_d = fq.pop_front();
                chk("fwft_rd_data", 32'(f_rd_data), 32'(exp_d));
                f_recv++;
            end
        end
        if (wv && f_wr_ready) fq.push_back(wd);
        @(posedge clk);
        #1;
        chk("fwft_count", 32'(f_count), 32'(fq.size()));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // wv wd rr | cnt full empty af ae ovf unf
        tbl[0]  = '{1'b1, 8'h11, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 8'h12, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 8'h13, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 8'h14, 1'b0, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 8'h15, 1'b0, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 8'h16, 1'b0, 4'd6, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 8'h17, 1'b0, 4'd7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 8'h18, 1'b0, 4'd8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 8'h19, 1'b0, 4'd8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 8'h00, 1'b1, 4'd7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 8'h00, 1'b1, 4'd6, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 8'h00, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 8'h00, 1'b1, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 8'h00, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 8'h00, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[15] = '{1'b0, 8'h00, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[16] = '{1'b0, 8'h00, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[17] = '{1'b0, 8'h00, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[18] = '{1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

        rst  = 1'b1;
        r_wv = 1'b0; r_wd = '0; r_rr = 1'b0;
        f_wv = 1'b0; f_wd = '0; f_rr = 1'b0;
        f_recv = 0;
        f_sent = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        chk("rst_count", 32'(r_count), 32'd0);
        chk("rst_empty", 32'(r_empty), 32'd1);
        chk("rst_full", 32'(r_full), 32'd0);
        chk("rst_wr_ready", 32'(r_wr_ready), 32'd1);
        chk("rst_almost_empty", 32'(r_ae), 32'd1);
        chk("rst_almost_full", 32'(r_af), 32'd0);
        chk("rst_rd_valid", 32'(r_rd_valid), 32'd0);
        chk("rst_rd_data", 32'(r_rd_data), 32'd0);
        chk("rst_overflow", 32'(r_ovf), 32'd0);
        chk("rst_underflow", 32'(r_unf), 32'd0);
        chk("rst_fwft_rd_valid", 32'(f_rd_valid), 32'd0);
        chk("rst_fwft_rd_data", 32'(f_rd_data), 32'd0);

        // Fill, overflow, drain, underflow with threshold flags
        for (int i = 0; i < 19; i++) begin
            reg_cycle(tbl[i].wv, tbl[i].wd, tbl[i].rr);
            chk($sformatf("tbl%0d_count", i), 32'(r_count), 32'(tbl[i].cnt));
            chk($sformatf("tbl%0d_full", i), 32'(r_full), 32'(tbl[i].full));
            chk($sformatf("tbl%0d_wr_ready", i), 32'(r_wr_ready), 32'(!tbl[i].full));
            chk($sformatf("tbl%0d_empty", i), 32'(r_empty), 32'(tbl[i].empty));
            chk($sformatf("tbl%0d_almost_full", i), 32'(r_af), 32'(tbl[i].af));
            chk($sformatf("tbl%0d_almost_empty", i), 32'(r_ae), 32'(tbl[i].ae));
            chk($sformatf("tbl%0d_overflow", i), 32'(r_ovf), 32'(tbl[i].ovf));
            chk($sformatf("tbl%0d_underflow", i), 32'(r_unf), 32'(tbl[i].unf));
        end
        chk("reg_rd_data_hold", 32'(r_rd_data), 32'h18);

        // Steady push/pop at count 4 across pointer wrap
        for (int k = 0; k < 4; k++) reg_cycle(1'b1, 8'(8'hA0 + k), 1'b0);
        for (int k = 0; k < 20; k++) begin
            reg_cycle(1'b1, 8'(8'hAA + k), 1'b1);
            chk("wrap_count4", 32'(r_count), 32'd4);
        end
        for (int k = 0; k < 4; k++) reg_cycle(1'b0, 8'h00, 1'b1);
        chk("wrap_drained_empty", 32'(r_empty), 32'd1);

        // Mid-stream reset at count 5, with inputs active during reset
        for (int k = 0; k < 5; k++) reg_cycle(1'b1, 8'(8'hC0 + k), 1'b0);
        chk("pre_rst_count", 32'(r_count), 32'd5);
        rst  = 1'b1;
        r_wv = 1'b1; r_wd = 8'hEE; r_rr = 1'b1;
        @(posedge clk);
        #1;
        rst  = 1'b0;
        r_wv = 1'b0; r_rr = 1'b0;
        rq.delete();
        chk("midrst_count", 32'(r_count), 32'd0);
        chk("midrst_empty", 32'(r_empty), 32'd1);
        chk("midrst_rd_valid", 32'(r_rd_valid), 32'd0);
        chk("midrst_rd_data", 32'(r_rd_data), 32'd0);
        chk("midrst_wr_ready", 32'(r_wr_ready), 32'd1);
        chk("midrst_almost_empty", 32'(r_ae), 32'd1);
        reg_cycle(1'b1, 8'h77, 1'b0);
        reg_cycle(1'b0, 8'h00, 1'b1);
        chk("post_rst_new_data", 32'(r_rd_data), 32'h77);

        // Show-ahead: push into empty, then hold with rd_ready low
        fwft_step(1'b1, 16'h005A, 1'b0);
        chk("fwft_first_valid", 32'(f_rd_valid), 32'd1);
        chk("fwft_first_data", 32'(f_rd_data), 32'h5A);
        for (int k = 0; k < 5; k++) begin
            fwft_step(k < 2, 16'(16'h005B + k), 1'b0);
            chk("fwft_hold_valid", 32'(f_rd_valid), 32'd1);
            chk("fwft_hold_data", 32'(f_rd_data), 32'h5A);
        end

        // Random ready/valid traffic, 1000 words plus the three held ones
        begin
            int cyc;
            cyc = 0;
            while ((f_recv < 1003) && (cyc < 20000)) begin
                fwft_step((f_sent < 1000) && ($urandom_range(0, 3) != 0),
                          16'(16'h1000 + f_sent),
                          $urandom_range(0, 2) != 0);
                if (f_wv && (f_sent < 1000) && (fq.size() > 0) &&
                    (fq[fq.size() - 1] == 16'(16'h1000 + f_sent))) begin
                    f_sent++;
                end
                cyc++;
            end
            chk("fwft_words_received", 32'(f_recv), 32'd1003);
        end
        chk("fwft_final_empty", 32'(f_empty), 32'd1);
        chk("fwft_underflow_tied", 32'(f_unf), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
